// File: rtl/hash_pkg.sv
// hash_pkg: shared widths and FSM state encoding for the hash message feeder
package hash_pkg;
  localparam int MSG_W = 8;
  localparam int COUNTER_W = 64;
  localparam int DIGEST_W = 32;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, GAP, WAIT_DIGEST} state_t;
endpackage

// File: rtl/hash_byte_fifo.sv
// hash_byte_fifo: synchronous byte FIFO with registered count and full/empty flags
module hash_byte_fifo
  import hash_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [MSG_W-1:0] din,
  input  logic             pop,
  output logic [MSG_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [MSG_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  // storage write, no reset needed since pointers gate visibility
  always_ff @(posedge clk)
    if (rst_n && do_push) mem[wp] <= din;
  // pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/hash_msg_feeder.sv
// hash_msg_feeder: buffers host bytes and paces them into the hash core, returns digest (optional watchdog: HASH_FEEDER_TIMEOUT_EN)
module hash_msg_feeder
  import hash_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BYTE_GAP = 6,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [COUNTER_W-1:0] msg_len,
  output logic                 busy,
  input  logic [MSG_W-1:0]     in_byte,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DIGEST_W-1:0]  digest,
  output logic                 digest_valid,
  output logic                 error,
  output logic [MSG_W-1:0]     hash_message,
  output logic                 hash_m_valid,
  output logic [COUNTER_W-1:0] hash_counter,
  input  logic [DIGEST_W-1:0]  hash_digest,
  input  logic                 hash_ready
);
  localparam int GW = $clog2(BYTE_GAP + 1);
  state_t state;
  logic [COUNTER_W-1:0] remaining;
  logic [GW-1:0] gap_cnt;
  logic ready_q, full, empty, pop;
  logic [MSG_W-1:0] fifo_q;
  assign busy = state != IDLE;
  assign in_ready = !full;
  assign pop = state == LOAD && !empty;
  hash_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   (in_byte),
    .pop   (pop),
    .dout  (fifo_q),
    .full  (full),
    .empty (empty)
  );
`ifdef HASH_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  // watchdog counter runs only while waiting for the digest, cleared on entry
  always_ff @(posedge clk)
    if (!rst_n) begin
      to_cnt <= '0;
      error <= 1'b0;
    end else begin
      to_cnt <= state == WAIT_DIGEST ? to_cnt + TW'(1) : '0;
      error <= state == WAIT_DIGEST && !(hash_ready && !ready_q) && to_cnt == TW'(TIMEOUT_CYCLES - 1);
    end
`else
  assign error = 1'b0;
`endif
  // sequencing FSM: ISSUE+GAP span BYTE_GAP-1 cycles, LOAD adds one, so pulses are exactly BYTE_GAP apart
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      remaining <= '0;
      gap_cnt <= '0;
      ready_q <= 1'b0;
      digest <= '0;
      digest_valid <= 1'b0;
      hash_message <= '0;
      hash_m_valid <= 1'b0;
      hash_counter <= '0;
    end else begin
      ready_q <= hash_ready;
      hash_m_valid <= 1'b0;
      digest_valid <= 1'b0;
      case (state)
        IDLE: if (start && msg_len != '0) begin
          hash_counter <= msg_len;
          remaining <= msg_len;
          state <= LOAD;
        end
        LOAD: if (!empty) begin
          hash_message <= fifo_q;
          hash_m_valid <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          gap_cnt <= '0;
          state <= GAP;
        end
        GAP: if (gap_cnt == GW'(BYTE_GAP - 3)) begin
          remaining <= remaining - 1'b1;
          state <= remaining == COUNTER_W'(1) ? WAIT_DIGEST : LOAD;
        end else gap_cnt <= gap_cnt + 1'b1;
        WAIT_DIGEST: if (hash_ready && !ready_q) begin
          digest <= hash_digest;
          digest_valid <= 1'b1;
          hash_counter <= '0;
          state <= IDLE;
        end
`ifdef HASH_FEEDER_TIMEOUT_EN
        else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          hash_counter <= '0;
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_hash_msg_feeder.sv
// tb_hash_msg_feeder: scoreboard bench for hash_msg_feeder with a behavioural hash core
module tb_hash_msg_feeder;
  import hash_pkg::*;
  localparam int BG = 6;
  localparam int TO = 8;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, hash_ready = 0;
  logic [63:0] msg_len = '0;
  logic [7:0] in_byte = '0;
  logic [31:0] hash_digest = '0;
  logic busy, in_ready, digest_valid, error, hash_m_valid;
  logic [31:0] digest;
  logic [7:0] hash_message;
  logic [63:0] hash_counter;
  hash_msg_feeder #(.FIFO_DEPTH(16), .BYTE_GAP(BG), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_len(msg_len), .busy(busy),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .digest(digest), .digest_valid(digest_valid), .error(error),
    .hash_message(hash_message), .hash_m_valid(hash_m_valid), .hash_counter(hash_counter),
    .hash_digest(hash_digest), .hash_ready(hash_ready)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int asserts = 0, fails = 0;
  logic [7:0] exp_bytes[$];
  logic [31:0] exp_dig[$];
  logic [63:0] exp_len = '0;
  logic [31:0] m_acc = '0;
  logic [7:0] mb;
  logic [31:0] md;
  int npm = 0, last_p = 0, first_p = 0, n_pulse = 0, n_dv = 0, acc_cyc = 0;
  bit strict = 1, mute = 0;
  function automatic logic [31:0] mix(input logic [31:0] a, input logic [7:0] b);
    return ({a[23:0], a[31:24] ^ b} + 32'h9E37_79B9) ^ {b, 24'd0};
  endfunction
  // behavioural core: absorbs bytes, raises hash_ready some cycles after the last one
  logic [31:0] c_acc = '0;
  logic [63:0] c_n = '0;
  int dly = 0;
  always @(posedge clk) begin
    if (!rst_n) dly <= 0;
    if (!rst_n || (hash_counter == '0 && !hash_m_valid)) begin
      c_acc <= '0;
      c_n <= '0;
    end else if (hash_m_valid) begin
      c_acc <= mix(c_acc, hash_message);
      c_n <= c_n + 1;
      hash_ready <= 1'b0;
      if (c_n + 1 == hash_counter) dly <= 6;
    end
    if (rst_n && dly != 0) begin
      dly <= dly - 1;
      if (dly == 1 && !mute) begin
        hash_ready <= 1'b1;
        hash_digest <= c_acc;
      end
    end
  end
  // output monitor: pops expected bytes and digests from the scoreboard
  always @(negedge clk) if (rst_n) begin
    if (hash_m_valid) begin
      n_pulse++;
      if (npm == 0) first_p = cyc;
      else begin
        asserts++;
        if (strict ? (cyc - last_p) != BG : (cyc - last_p) < BG) begin
          fails++;
          $display("FAIL pulse_spacing: got %0d cycles, required %s%0d", cyc - last_p, strict ? "" : ">=", BG);
        end
      end
      last_p = cyc;
      mb = exp_bytes.size() != 0 ? exp_bytes.pop_front() : 8'hxx;
      asserts++;
      if (hash_message !== mb) begin
        fails++;
        $display("FAIL hash_message: got %02h, required %02h", hash_message, mb);
      end
      asserts++;
      if (hash_counter !== exp_len) begin
        fails++;
        $display("FAIL hash_counter: got %0d, required %0d", hash_counter, exp_len);
      end
      m_acc = mix(m_acc, mb);
      npm++;
      if (64'(npm) == exp_len) exp_dig.push_back(m_acc);
    end
    if (digest_valid) begin
      n_dv++;
      md = exp_dig.size() != 0 ? exp_dig.pop_front() : 32'hxxxx_xxxx;
      asserts++;
      if (digest !== md) begin
        fails++;
        $display("FAIL digest: got %08h, required %08h", digest, md);
      end
      asserts++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL busy_at_digest: got %b, required 0", busy);
      end
    end
  end
  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    in_byte = b;
    in_valid = 1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    asserts++;
    if (n >= 500) begin
      fails++;
      $display("FAIL push_timeout: in_ready stayed 0, required 1");
    end else exp_bytes.push_back(b);
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic start_cmd(input logic [63:0] len, input bit accept);
    start = 1;
    msg_len = len;
    if (accept) begin
      exp_len = len;
      npm = 0;
      m_acc = '0;
    end
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_dv();
    int n = 0;
    while (!digest_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    asserts++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL digest_timeout: digest_valid got 0, required 1");
    end
    @(negedge clk);
    asserts++;
    if (digest_valid !== 1'b0) begin
      fails++;
      $display("FAIL dv_pulse_width: got %b, required 0", digest_valid);
    end
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    asserts += 8;
    if (busy !== 0) begin fails++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (in_ready !== 1) begin fails++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    if (digest !== 0) begin fails++; $display("FAIL rst_digest: got %h, required 0", digest); end
    if (digest_valid !== 0) begin fails++; $display("FAIL rst_dv: got %b, required 0", digest_valid); end
    if (error !== 0) begin fails++; $display("FAIL rst_error: got %b, required 0", error); end
    if (hash_message !== 0) begin fails++; $display("FAIL rst_msg: got %h, required 0", hash_message); end
    if (hash_m_valid !== 0) begin fails++; $display("FAIL rst_mvalid: got %b, required 0", hash_m_valid); end
    if (hash_counter !== 0) begin fails++; $display("FAIL rst_counter: got %0d, required 0", hash_counter); end
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_basic();
    int p0 = n_pulse, d0 = n_dv;
    strict = 1;
    push_byte(8'h61);
    push_byte(8'h62);
    push_byte(8'h63);
    start_cmd(3, 1);
    asserts++;
    if (busy !== 1) begin fails++; $display("FAIL basic_busy: got %b, required 1", busy); end
    wait_dv();
    asserts += 2;
    if (n_pulse - p0 != 3) begin fails++; $display("FAIL basic_pulses: got %0d, required 3", n_pulse - p0); end
    if (n_dv - d0 != 1) begin fails++; $display("FAIL basic_dv_count: got %0d, required 1", n_dv - d0); end
  endtask
  task automatic test_full();
    strict = 1;
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    asserts++;
    if (in_ready !== 0) begin fails++; $display("FAIL full_in_ready: got %b, required 0", in_ready); end
    start_cmd(17, 1);
    push_byte(8'h2F);
    asserts++;
    if (acc_cyc < first_p) begin fails++; $display("FAIL full_17th_early: accepted cycle %0d, required >= %0d", acc_cyc, first_p); end
    wait_dv();
  endtask
  task automatic test_ignored_starts();
    int p0 = n_pulse;
    bit saw = 0;
    start_cmd(0, 0);
    repeat (5) begin
      saw |= busy;
      @(negedge clk);
    end
    asserts += 2;
    if (saw !== 0) begin fails++; $display("FAIL zero_len_busy: got 1, required 0"); end
    if (n_pulse != p0) begin fails++; $display("FAIL zero_len_pulses: got %0d, required 0", n_pulse - p0); end
    strict = 1;
    push_byte(8'hC1);
    push_byte(8'hC2);
    start_cmd(2, 1);
    repeat (3) @(negedge clk);
    start_cmd(9, 0);
    repeat (2) @(negedge clk);
    asserts++;
    if (hash_counter !== 64'd2) begin fails++; $display("FAIL busy_start_counter: got %0d, required 2", hash_counter); end
    wait_dv();
  endtask
  task automatic test_starve();
    int p0 = n_pulse, n = 0;
    strict = 0;
    start_cmd(2, 1);
    repeat (10) @(negedge clk);
    asserts += 2;
    if (busy !== 1) begin fails++; $display("FAIL starve_busy: got %b, required 1", busy); end
    if (n_pulse != p0) begin fails++; $display("FAIL starve_early_pulse: got %0d, required 0", n_pulse - p0); end
    push_byte(8'hA5);
    while (n_pulse == p0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    asserts++;
    if (n_pulse == p0 || first_p - acc_cyc < 1 || first_p - acc_cyc > 2) begin
      fails++;
      $display("FAIL starve_latency: got %0d cycles, required 1..2", first_p - acc_cyc);
    end
    push_byte(8'h5A);
    wait_dv();
  endtask
`ifdef HASH_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] d0 = digest;
    int p0 = n_pulse, n = 0;
    mute = 1;
    strict = 1;
    push_byte(8'h77);
    start_cmd(1, 1);
    while (!error && n < 100) begin
      @(negedge clk);
      n++;
    end
    asserts += 4;
    if (n_pulse - p0 != 1 || cyc - first_p != 5 + TO) begin fails++; $display("FAIL timeout_cycle: got %0d, required %0d", cyc - first_p, 5 + TO); end
    if (digest !== d0) begin fails++; $display("FAIL timeout_digest: got %h, required %h", digest, d0); end
    if (digest_valid !== 0) begin fails++; $display("FAIL timeout_dv: got %b, required 0", digest_valid); end
    if (busy !== 0) begin fails++; $display("FAIL timeout_busy: got %b, required 0", busy); end
    exp_dig.delete();
    mute = 0;
    @(negedge clk);
  endtask
`endif
  task automatic test_reset_mid();
    int n = 0, p0;
    strict = 1;
    for (int i = 0; i < 4; i++) push_byte(8'hE0 + 8'(i));
    start_cmd(4, 1);
    while (npm < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    asserts += 7;
    if (busy !== 0) begin fails++; $display("FAIL mid_busy: got %b, required 0", busy); end
    if (in_ready !== 1) begin fails++; $display("FAIL mid_in_ready: got %b, required 1", in_ready); end
    if (hash_m_valid !== 0) begin fails++; $display("FAIL mid_mvalid: got %b, required 0", hash_m_valid); end
    if (hash_counter !== 0) begin fails++; $display("FAIL mid_counter: got %0d, required 0", hash_counter); end
    if (hash_message !== 0) begin fails++; $display("FAIL mid_msg: got %h, required 0", hash_message); end
    if (digest !== 0) begin fails++; $display("FAIL mid_digest: got %h, required 0", digest); end
    if (digest_valid !== 0) begin fails++; $display("FAIL mid_dv: got %b, required 0", digest_valid); end
    rst_n = 1;
    exp_bytes.delete();
    exp_dig.delete();
    npm = 0;
    p0 = n_pulse;
    repeat (3) @(negedge clk);
    asserts++;
    if (n_pulse != p0) begin fails++; $display("FAIL mid_stray_pulse: got %0d, required 0", n_pulse - p0); end
    push_byte(8'h3C);
    push_byte(8'h3D);
    start_cmd(2, 1);
    wait_dv();
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_ignored_starts();
    test_starve();
`ifdef HASH_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/hash_msg_feeder.md
# hash_msg_feeder

Host-side driver for the full DES S-box hash core. It buffers message bytes from the host in a small FIFO and, after a start command with the message length, presents the bytes to the core's byte interface at the pace the core's FSM requires. It then waits for the core's hash-ready indication and returns the 32-bit digest to the host with a one-cycle valid pulse. It sits between the host/bus logic and the hash core instance, on the initiator side of the core's message/M_valid/counter/digest interface.

## Interface
- FIFO_DEPTH, 16, byte FIFO entries (power of two, ≥2)
- BYTE_GAP, 6, cycles from one M_valid pulse to the next (≥6, covers core S0→S1→S2×4)
- TIMEOUT_CYCLES, 256, WAIT_DIGEST watchdog limit (used only with macro)

Ports (clock and reset first):
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle command; sampled only in IDLE
- msg_len  in  64  message length in bytes, sampled with start
- busy  out  1  high from cycle after accepted start until return to IDLE
- in_byte  in  8  host message byte
- in_valid  in  1  host byte valid
- in_ready  out  1  FIFO not full (from registered count)
- digest  out  32  last captured digest; holds until next capture
- digest_valid  out  1  one-cycle pulse when digest updated
- error  out  1  one-cycle timeout pulse (0 without macro)
- hash_message  out  8  to core message
- hash_m_valid  out  1  to core M_valid
- hash_counter  out  64  to core counter
- hash_digest  in  32  from core digest_out
- hash_ready  in  1  from core hash_ready (level, cleared by core on next byte)

## Operation
- Reset: all outputs 0, FIFO emptied, state IDLE, edge detector cleared. Reset asserted mid-message aborts the message; no digest_valid/error.
- FIFO: push when in_valid && in_ready, independent of FSM state (prefetch allowed). Full: in_ready=0 even if pop occurs the same cycle. Push into an empty FIFO is not poppable in the same cycle. Bytes beyond msg_len stay queued for the next message.
- FSM states:
  - IDLE: start && msg_len!=0 → latch msg_len into hash_counter and remaining count → LOAD. start with msg_len==0 is ignored (busy stays 0).
  - LOAD: FIFO non-empty → pop, drive hash_message, hash_m_valid=1 for exactly one cycle (ISSUE) → GAP.
  - GAP: count BYTE_GAP−1 cycles; remaining−1; remaining==0 → WAIT_DIGEST, else → LOAD.
  - WAIT_DIGEST: rising edge of hash_ready (registered previous sample 0, current 1) → digest<=hash_digest, digest_valid=1 → IDLE.
- hash_counter is held constant from start acceptance until return to IDLE; it is 0 in IDLE.
- hash_message holds its last value between pulses.
- start during busy is ignored; no queuing of commands.
- FIFO empty in LOAD: wait indefinitely (no timeout).

## Timing
- Start at cycle T → busy=1 at T+1; first hash_m_valid at T+2 if FIFO was non-empty at T+1.
- Consecutive hash_m_valid pulses are exactly BYTE_GAP cycles apart when FIFO never starves; never closer.
- digest and digest_valid are registered: both update at the cycle after the hash_ready rising edge is detected; busy falls in the same cycle.
- Next start is accepted the cycle after digest_valid.

## Configuration
- HASH_FEEDER_TIMEOUT_EN defined: WAIT_DIGEST counts cycles; reaching TIMEOUT_CYCLES without a hash_ready rising edge → error=1 for one cycle, digest unchanged, digest_valid=0, → IDLE. Counter cleared on entry.
- Undefined: no counter, error tied to 0, WAIT_DIGEST waits indefinitely.

## Structure
- Shared package hash_pkg: state enum (IDLE, LOAD, ISSUE, GAP, WAIT_DIGEST), MSG_W=8, COUNTER_W=64, DIGEST_W=32.
- One sub-module: hash_byte_fifo (synchronous FIFO with registered count, full/empty flags, parameter DEPTH).

## Test plan
- Push 0x61 0x62 0x63, start with msg_len=3 → 3 hash_m_valid pulses, 6 cycles apart, hash_counter=3 throughout; digest equals the core model result, digest_valid pulses once.
- Push 17 bytes with FIFO_DEPTH=16 → in_ready=0 after 16 pushes; 17th byte accepted once the first pop occurs.
- start with msg_len=0 → busy stays 0, no hash_m_valid; a start issued while busy=1 → ignored, hash_counter unchanged.
- Start msg_len=2 with an empty FIFO, push a byte 10 cycles later → first hash_m_valid 1–2 cycles after the push; no timeout.
- Macro on, TIMEOUT_CYCLES=8, hash_ready held 0 → error pulse 8 cycles after WAIT_DIGEST entry, digest unchanged, back to IDLE.
- rst_n=0 during GAP of byte 2 of 4 → next cycle all outputs 0, FIFO empty, busy=0; a fresh message afterwards completes normally.
